// File: rtl/pmp_unit_pkg.sv
// Shared types and constants for the physical memory protection unit.
// Holds the pmpcfg byte layout, the address-matching mode encoding, the
// CSR address map and the request size/operation/privilege encodings.
package pmp_unit_pkg;

  localparam int unsigned PMP_MAX_ENTRIES = 16;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

  typedef enum logic [1:0] {
    PmpOff   = 2'b00,
    PmpTor   = 2'b01,
    PmpNa4   = 2'b10,
    PmpNapot = 2'b11
  } pmp_a_e;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_a_e    a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } req_size_e;

  typedef enum logic [1:0] {
    OperRead  = 2'b00,
    OperWrite = 2'b01,
    OperExec  = 2'b10,
    OperRsvd  = 2'b11
  } req_oper_e;

  typedef enum logic [1:0] {
    PrivU    = 2'b00,
    PrivS    = 2'b01,
    PrivRsvd = 2'b10,
    PrivM    = 2'b11
  } priv_e;

  // WARL legalisation of a written cfg byte: reserved bits read 0 and the
  // write-without-read combination is not representable, so W is dropped.
  function automatic pmp_cfg_t pmp_cfg_legalize(input logic [7:0] raw);
    pmp_cfg_t c;
    c      = pmp_cfg_t'(raw);
    c.rsvd = 2'b00;
    c.w    = raw[1] & raw[0];
    return c;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational region match for a single PMP entry.
// Ports:
//   span_lo / span_hi : first and last byte of the access (inclusive)
//   mode              : address-matching mode of this entry
//   addr_prev/addr_own: pmpaddr of the previous entry (TOR lower bound) and this entry
//   full              : every byte of the span lies inside the region
//   partial           : some, but not all, bytes of the span lie inside the region
// Arithmetic is 36 bits wide so that a NAPOT region covering the whole
// 34-bit pmpaddr space (exclusive end 2^35) and TOR bounds never wrap.
module pmp_entry_match
  import pmp_unit_pkg::*;
(
  input  logic [35:0] span_lo,
  input  logic [35:0] span_hi,
  input  pmp_a_e      mode,
  input  logic [31:0] addr_prev,
  input  logic [31:0] addr_own,
  output logic        full,
  output logic        partial
);

  logic [35:0] own_w;
  logic [35:0] prev_w;
  logic [35:0] napot_mask;
  logic [35:0] region_lo;
  logic [35:0] region_hi;
  logic        non_empty;
  logic        inside_all;
  logic        overlap;

  assign own_w  = {4'b0000, addr_own};
  assign prev_w = {4'b0000, addr_prev};

  // Trailing ones plus the following zero, i.e. the low t+1 word-address bits.
  assign napot_mask = own_w ^ (own_w + 36'd1);

  always_comb begin
    region_lo = '0;
    region_hi = '0;
    unique case (mode)
      PmpTor: begin
        region_lo = prev_w << 2;
        region_hi = own_w << 2;
      end
      PmpNa4: begin
        region_lo = own_w << 2;
        region_hi = (own_w << 2) + 36'd4;
      end
      PmpNapot: begin
        region_lo = (own_w & ~napot_mask) << 2;
        region_hi = ((own_w & ~napot_mask) << 2) + ((napot_mask + 36'd1) << 2);
      end
      default: begin
        region_lo = '0;
        region_hi = '0;
      end
    endcase
  end

  // Region is the half-open interval [region_lo, region_hi).
  assign non_empty  = region_lo < region_hi;
  assign inside_all = (span_lo >= region_lo) && (span_hi < region_hi);
  assign overlap    = (span_lo < region_hi) && (span_hi >= region_lo);

  assign full    = non_empty && inside_all;
  assign partial = non_empty && overlap && !inside_all;

endmodule

// File: rtl/pmp_unit.sv
// Parametrised RISC-V physical memory protection unit.
// Owns pmpcfg/pmpaddr storage with WARL and lock rules, checks each request
// against all entries through a one-stage valid/ready pipeline and captures
// the address of the first denied access.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   csr_we/csr_addr/csr_wdata      : CSR write port (pmpcfg0..3, pmpaddr0..15)
//   csr_rdata                      : combinational read of csr_addr
//   req_valid/req_ready/req_*      : check request (address, size, operation, privilege)
//   rsp_valid/rsp_ready/rsp_allow  : registered check result
//   rsp_oper                       : operation echo for cause selection
//   fault_valid/fault_addr         : sticky first-fault capture, cleared by fault_clr
module pmp_unit
  import pmp_unit_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned XLEN        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_oper,
  input  logic [1:0]  req_priv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_allow,
  output logic [1:0]  rsp_oper,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);

  // Extra top slot is tied to zero so entry i can always look at entry i+1.
  pmp_cfg_t    cfg     [PMP_MAX_ENTRIES+1];
  logic [31:0] paddr   [PMP_MAX_ENTRIES];
  logic        full    [PMP_MAX_ENTRIES];
  logic        partial [PMP_MAX_ENTRIES];

  logic [35:0] span_lo;
  logic [35:0] span_hi;

  assign span_lo = {4'b0000, req_addr};
  assign span_hi = span_lo + (36'd1 << req_size) - 36'd1;

  assign cfg[PMP_MAX_ENTRIES] = '0;

  for (genvar i = 0; i < PMP_MAX_ENTRIES; i++) begin : g_entry
    if (i < NUM_ENTRIES) begin : g_impl
      localparam int unsigned Prev = (i == 0) ? 0 : i - 1;

      pmp_cfg_t    cfg_q, cfg_d;
      logic [31:0] addr_q, addr_d;
      logic        cfg_sel;
      logic        addr_sel;
      logic        addr_lock;

      assign cfg_sel  = csr_we && (csr_addr == (PMPCFG_BASE + 12'(i / 4)));
      assign addr_sel = csr_we && (csr_addr == (PMPADDR_BASE + 12'(i)));
      // pmpaddr is also frozen when it serves as the lower bound of a locked TOR entry.
      assign addr_lock = cfg_q.l || (cfg[i+1].l && (cfg[i+1].a == PmpTor));

      always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        if (cfg_sel && !cfg_q.l) begin
          cfg_d = pmp_cfg_legalize(csr_wdata[8*(i%4) +: 8]);
        end
        if (addr_sel && !addr_lock) begin
          addr_d = csr_wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cfg_q  <= '0;
          addr_q <= '0;
        end else begin
          cfg_q  <= cfg_d;
          addr_q <= addr_d;
        end
      end

      assign cfg[i]   = cfg_q;
      assign paddr[i] = addr_q;

      logic [31:0] addr_prev;
      assign addr_prev = (i == 0) ? 32'd0 : paddr[Prev];

      pmp_entry_match u_match (
        .span_lo   (span_lo),
        .span_hi   (span_hi),
        .mode      (cfg_q.a),
        .addr_prev (addr_prev),
        .addr_own  (addr_q),
        .full      (full[i]),
        .partial   (partial[i])
      );
    end else begin : g_none
      assign cfg[i]     = '0;
      assign paddr[i]   = '0;
      assign full[i]    = 1'b0;
      assign partial[i] = 1'b0;
    end
  end

  // CSR read mux.
  always_comb begin
    csr_rdata = '0;
    if (csr_addr[11:2] == PMPCFG_BASE[11:2]) begin
      for (int b = 0; b < 4; b++) begin
        csr_rdata[8*b +: 8] = cfg[{csr_addr[1:0], 2'(b)}];
      end
    end else if (csr_addr[11:4] == PMPADDR_BASE[11:4]) begin
      csr_rdata = paddr[csr_addr[3:0]];
    end
  end

  // Priority decision: lowest-index matching entry decides.
  logic check_allow;
  logic found;

  always_comb begin
    check_allow = (priv_e'(req_priv) == PrivM);
    found       = 1'b0;
    for (int i = 0; i < PMP_MAX_ENTRIES; i++) begin
      if (!found && (full[i] || partial[i])) begin
        found = 1'b1;
        if (partial[i]) begin
          check_allow = 1'b0;
        end else if ((priv_e'(req_priv) == PrivM) && !cfg[i].l) begin
          check_allow = 1'b1;
        end else begin
          case (req_oper_e'(req_oper))
            OperRead:  check_allow = cfg[i].r;
            OperWrite: check_allow = cfg[i].w;
            OperExec:  check_allow = cfg[i].x;
            default:   check_allow = 1'b0;
          endcase
        end
      end
    end
    if ((req_size_e'(req_size) == SizeRsvd) || (req_oper_e'(req_oper) == OperRsvd)) begin
      check_allow = 1'b0;
    end
  end

  // Response stage and fault capture.
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_allow_q, rsp_allow_d;
  logic [1:0]  rsp_oper_q, rsp_oper_d;
  logic        fault_valid_q, fault_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        accept;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_allow_d   = rsp_allow_q;
    rsp_oper_d    = rsp_oper_q;
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_allow_d = check_allow;
      rsp_oper_d  = req_oper;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
    // A clear in the same cycle frees the slot for the new fault.
    if (accept && !check_allow && (!fault_valid_q || fault_clr)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_allow_q   <= 1'b0;
      rsp_oper_q    <= 2'b00;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_allow_q   <= rsp_allow_d;
      rsp_oper_q    <= rsp_oper_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_allow   = rsp_allow_q;
  assign rsp_oper    = rsp_oper_q;
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_pmp_unit.sv
module tb_pmp_unit;

  logic        clk;
  logic        rst;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [1:0]  req_oper;
  logic [1:0]  req_priv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_allow;
  logic [1:0]  rsp_oper;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_clr;

  int n_checks;
  int n_fail;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;
  localparam logic [1:0] OP_R = 2'b00, OP_W = 2'b01, OP_X = 2'b10, OP_RS = 2'b11;
  localparam logic [1:0] PV_U = 2'b00, PV_M = 2'b11;

  pmp_unit #(
    .NUM_ENTRIES (16),
    .XLEN        (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_oper    (req_oper),
    .req_priv    (req_priv),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_allow   (rsp_allow),
    .rsp_oper    (rsp_oper),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_clr   (fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_we    = 1'b0;
  endtask

  task automatic csr_rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_addr = a;
    #1;
    check_eq(tag, csr_rdata, exp);
  endtask

  // One request with rsp_ready held high; checks the registered result.
  task automatic req_chk(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic [1:0] op, input logic [1:0] pv, input logic clr,
                         input logic exp_allow);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_oper  = op;
    req_priv  = pv;
    fault_clr = clr;
    #1;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    if (!req_ready) check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    fault_clr = 1'b0;
    check_eq({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    check_eq(tag, {31'd0, rsp_allow}, {31'd0, exp_allow});
    check_eq({tag, "_op"}, {30'd0, rsp_oper}, {30'd0, op});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_oper  = '0;
    req_priv  = '0;
    rsp_ready = 1'b1;
    fault_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_allow", {31'd0, rsp_allow}, 32'd0);
    check_eq("rst_rsp_oper", {30'd0, rsp_oper}, 32'd0);
    check_eq("rst_fault_valid", {31'd0, fault_valid}, 32'd0);
    check_eq("rst_fault_addr", fault_addr, 32'd0);
    csr_rd_chk("rst_cfg0", 12'h3A0, 32'd0);
    csr_rd_chk("rst_addr0", 12'h3B0, 32'd0);

    // Lock semantics
    csr_wr(12'h3A0, 32'h0000_008F);
    csr_rd_chk("lock_cfg0", 12'h3A0, 32'h0000_008F);
    csr_wr(12'h3B0, 32'h0000_1234);
    csr_rd_chk("lock_addr0", 12'h3B0, 32'd0);
    csr_wr(12'h3A0, 32'h0000_0089);
    csr_rd_chk("lock_cfg0_rewr", 12'h3A0, 32'h0000_008F);
    csr_wr(12'h3B2, 32'h0000_0055);
    csr_rd_chk("addr2_wr", 12'h3B2, 32'h0000_0055);
    csr_wr(12'h3A0, 32'h8800_0000);
    csr_rd_chk("cfg0_byte3", 12'h3A0, 32'h8800_008F);
    csr_wr(12'h3B2, 32'h0000_0066);
    csr_rd_chk("tor_lock_addr2", 12'h3B2, 32'h0000_0055);
    csr_wr(12'h3B3, 32'h0000_0077);
    csr_rd_chk("lock_addr3", 12'h3B3, 32'd0);
    csr_rd_chk("unmapped", 12'h3C0, 32'd0);

    // Locked NAPOT R-only region at 0..4 KiB, then WARL on byte1
    do_reset();
    csr_wr(12'h3B0, 32'h0000_01FF);
    csr_wr(12'h3A0, 32'h0000_0099);
    csr_rd_chk("blk_cfg0", 12'h3A0, 32'h0000_0099);
    req_chk("blk_u_wr", 32'h10, SZ_W, OP_W, PV_U, 1'b0, 1'b0);
    req_chk("blk_u_rd", 32'h10, SZ_W, OP_R, PV_U, 1'b0, 1'b1);
    req_chk("blk_m_wr", 32'h10, SZ_W, OP_W, PV_M, 1'b0, 1'b0);
    req_chk("blk_m_rd", 32'h10, SZ_W, OP_R, PV_M, 1'b0, 1'b1);
    csr_wr(12'h3A0, 32'h0000_6A00);
    csr_rd_chk("warl_cfg1", 12'h3A0, 32'h0000_0899);
    req_chk("blk_m_nomatch", 32'h1000, SZ_W, OP_W, PV_M, 1'b0, 1'b1);

    // TOR region [0x1000, 0x2000) read-only
    do_reset();
    csr_wr(12'h3B0, 32'h0000_0400);
    csr_wr(12'h3B1, 32'h0000_0800);
    csr_wr(12'h3A0, 32'h0000_0900);
    req_chk("tor_rd", 32'h1000, SZ_W, OP_R, PV_U, 1'b0, 1'b1);
    check_eq("tor_nofault", {31'd0, fault_valid}, 32'd0);
    req_chk("tor_wr", 32'h1000, SZ_W, OP_W, PV_U, 1'b0, 1'b0);
    check_eq("tor_fault_v", {31'd0, fault_valid}, 32'd1);
    check_eq("tor_fault_a", fault_addr, 32'h1000);
    req_chk("tor_rd_out", 32'h2000, SZ_W, OP_R, PV_U, 1'b0, 1'b0);
    check_eq("tor_fault_keep", fault_addr, 32'h1000);
    req_chk("tor_m_out", 32'h2000, SZ_W, OP_R, PV_M, 1'b0, 1'b1);
    req_chk("tor_partial", 32'h1FFE, SZ_W, OP_R, PV_U, 1'b0, 1'b0);

    // Partial overlap against NA4 at 0x100
    do_reset();
    csr_wr(12'h3B0, 32'h0000_0040);
    csr_wr(12'h3A0, 32'h0000_0011);
    req_chk("na4_part_u", 32'h102, SZ_W, OP_R, PV_U, 1'b0, 1'b0);
    req_chk("na4_part_m", 32'h102, SZ_W, OP_R, PV_M, 1'b0, 1'b0);
    req_chk("na4_full", 32'h100, SZ_W, OP_R, PV_U, 1'b0, 1'b1);
    req_chk("na4_byte", 32'h103, SZ_B, OP_R, PV_U, 1'b0, 1'b1);
    req_chk("na4_half_part", 32'h103, SZ_H, OP_R, PV_U, 1'b0, 1'b0);

    // Priority between nested NAPOT regions
    do_reset();
    csr_wr(12'h3B0, 32'h0000_01FF);
    csr_wr(12'h3B1, 32'h0000_1FFF);
    csr_wr(12'h3A0, 32'h0000_1D1B);
    req_chk("pri_x_e0", 32'h10, SZ_W, OP_X, PV_U, 1'b0, 1'b0);
    req_chk("pri_x_e1", 32'h2000, SZ_W, OP_X, PV_U, 1'b0, 1'b1);
    req_chk("pri_x_none", 32'h10000, SZ_W, OP_X, PV_U, 1'b0, 1'b0);
    req_chk("pri_m_x", 32'h10, SZ_W, OP_X, PV_M, 1'b0, 1'b1);
    req_chk("rsvd_size", 32'h2000, SZ_R, OP_R, PV_M, 1'b0, 1'b0);
    req_chk("rsvd_oper", 32'h2000, SZ_W, OP_RS, PV_M, 1'b0, 1'b0);

    // Handshake: backpressure then back-to-back transfers
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h2000;
    req_size  = SZ_W;
    req_oper  = OP_X;
    req_priv  = PV_U;
    @(negedge clk);
    check_eq("hs_first_vld", {31'd0, rsp_valid}, 32'd1);
    check_eq("hs_first_allow", {31'd0, rsp_allow}, 32'd1);
    req_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("hs_stall_ready", {31'd0, req_ready}, 32'd0);
      check_eq("hs_stall_vld", {31'd0, rsp_valid}, 32'd1);
      check_eq("hs_stall_allow", {31'd0, rsp_allow}, 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("hs_release_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check_eq("hs_b2b1_vld", {31'd0, rsp_valid}, 32'd1);
    check_eq("hs_b2b1_allow", {31'd0, rsp_allow}, 32'd0);
    req_addr = 32'h2000;
    @(negedge clk);
    check_eq("hs_b2b2_vld", {31'd0, rsp_valid}, 32'd1);
    check_eq("hs_b2b2_allow", {31'd0, rsp_allow}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("hs_drain", {31'd0, rsp_valid}, 32'd0);

    // CSR write coincident with accept sees old config
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h2000;
    req_oper  = OP_X;
    req_priv  = PV_U;
    csr_we    = 1'b1;
    csr_addr  = 12'h3A0;
    csr_wdata = 32'h0000_191B;
    @(negedge clk);
    csr_we    = 1'b0;
    req_valid = 1'b0;
    check_eq("csr_same_cycle", {31'd0, rsp_allow}, 32'd1);
    csr_rd_chk("csr_new_cfg", 12'h3A0, 32'h0000_191B);
    req_chk("csr_new_deny", 32'h2000, SZ_W, OP_X, PV_U, 1'b0, 1'b0);

    // Fault capture
    do_reset();
    req_chk("f_a0", 32'hA0, SZ_W, OP_R, PV_U, 1'b0, 1'b0);
    check_eq("f_a0_v", {31'd0, fault_valid}, 32'd1);
    check_eq("f_a0_a", fault_addr, 32'hA0);
    req_chk("f_b0", 32'hB0, SZ_W, OP_R, PV_U, 1'b0, 1'b0);
    check_eq("f_b0_keep", fault_addr, 32'hA0);
    req_chk("f_c0", 32'hC0, SZ_W, OP_R, PV_U, 1'b1, 1'b0);
    check_eq("f_c0_v", {31'd0, fault_valid}, 32'd1);
    check_eq("f_c0_a", fault_addr, 32'hC0);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("f_clr", {31'd0, fault_valid}, 32'd0);

    // Reset while a request is presented drops it
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'hE0;
    req_oper  = OP_R;
    req_priv  = PV_U;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    check_eq("rst_drop_vld", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_fault_v2", {31'd0, fault_valid}, 32'd0);
    check_eq("rst_fault_a2", fault_addr, 32'd0);
    @(negedge clk);
    check_eq("rst_drop_vld2", {31'd0, rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
